// File: rtl/bfm_apb_cmd_master.sv
// bfm_apb_cmd_master: command-driven APB master BFM on the PCLK_PM domain.
// Commands are queued in a FIFO and each one runs as an APB SETUP/ACCESS
// transfer. The result comes back on a rsp_valid/rsp_ready handshake.
// A per-transfer ACCESS timeout guards against a slave that never answers.
// Optional masked read-data compare: define BFM_APBMASTER_RDCHK_EN.
//
// Handshakes: cmd and rsp use valid/ready semantics. A beat transfers on a
// rising PCLK_PM edge where valid and ready are both high. Once rsp_valid is
// high, it and all rsp_* fields stay stable until that transfer happens.
module bfm_apb_cmd_master #(
  parameter int CMD_DEPTH = 4,
  parameter int TIMEOUT   = 1024,
  parameter int TPD       = 1
) (
  input  logic        PCLK_PM,
  input  logic        PRESETN_PM,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [31:0] cmd_exp,
  input  logic [31:0] cmd_mask,
  output logic        PSEL_PM,
  output logic [31:0] PADDR_PM,
  output logic        PWRITE_PM,
  output logic        PENABLE_PM,
  output logic [31:0] PWDATA_PM,
  input  logic [31:0] PRDATA_PM,
  input  logic        PREADY_PM,
  input  logic        PSLVERR_PM,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        rsp_timeout,
  output logic        rsp_mismatch,
  output logic        busy
);

  localparam int AW = $clog2(CMD_DEPTH);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam bit TO_EN = (TIMEOUT != 0);
  localparam logic [TW-1:0] TO_LAST = TO_EN ? TW'(TIMEOUT - 1) : '0;
`ifdef BFM_APBMASTER_RDCHK_EN
  localparam int FW = 129;
`else
  localparam int FW = 65;
`endif

  // TPD is kept as an interface parameter only; this synthesizable model
  // drives every output with zero delay.
  if (CMD_DEPTH < 2 || CMD_DEPTH > 16 || (CMD_DEPTH & (CMD_DEPTH - 1)) != 0 || TPD < 0) begin : g_param_check
    $error("bfm_apb_cmd_master: CMD_DEPTH must be a power of 2 in 2..16 and TPD >= 0");
  end

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP} state_t;
  state_t state_q, state_d;

  // Command FIFO
  logic [FW-1:0] mem [CMD_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          push, pop;
  logic [FW-1:0] head, push_word;
  logic          h_write;
  logic [31:0]   h_addr, h_wdata;
  logic          rd_miss;

  assign cmd_ready = (count != (AW+1)'(CMD_DEPTH));
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state_q == S_IDLE) && (count != '0);
  assign head      = mem[rd_ptr];
  assign h_write   = head[64];
  assign h_addr    = head[63:32];
  assign h_wdata   = head[31:0];
  assign busy      = (count != '0) || (state_q != S_IDLE);

`ifdef BFM_APBMASTER_RDCHK_EN
  logic [31:0] cur_exp, cur_mask;
  assign push_word = {cmd_exp, cmd_mask, cmd_write, cmd_addr, cmd_wdata};
  assign rd_miss   = ((PRDATA_PM ^ cur_exp) & cur_mask) != 32'd0;

  // Latch the compare operands of the transfer being launched.
  always_ff @(posedge PCLK_PM or negedge PRESETN_PM) begin
    if (!PRESETN_PM) begin
      cur_exp  <= '0;
      cur_mask <= '0;
    end else if (pop) begin
      cur_exp  <= head[128:97];
      cur_mask <= head[96:65];
    end
  end

  // Report every failed masked read compare as it completes.
  always_ff @(posedge PCLK_PM) begin
    if (state_q == S_ACCESS && PREADY_PM && !PWRITE_PM && rd_miss)
      $display("bfm_apb_cmd_master: read compare miss addr=%08h actual=%08h expected=%08h mask=%08h",
               PADDR_PM, PRDATA_PM, cur_exp, cur_mask);
  end
`else
  logic unused_cmp;
  assign push_word  = {cmd_write, cmd_addr, cmd_wdata};
  assign rd_miss    = 1'b0;
  assign unused_cmp = ^{cmd_exp, cmd_mask};
`endif

  // FIFO pointers and occupancy; a simultaneous push and pop keeps count.
  always_ff @(posedge PCLK_PM or negedge PRESETN_PM) begin
    if (!PRESETN_PM) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + (AW+1)'(1);
      else if (pop && !push) count <= count - (AW+1)'(1);
    end
  end

  // FIFO storage; stale entries are harmless once the pointers reset.
  always_ff @(posedge PCLK_PM) begin
    if (push) mem[wr_ptr] <= push_word;
  end

  // Registered APB and response outputs
  logic          psel_d, penable_d, pwrite_d;
  logic [31:0]   paddr_d, pwdata_d, rsp_rdata_d;
  logic          rsp_valid_d, rsp_err_d, rsp_timeout_d, rsp_mismatch_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;

  // State and output registers; reset drops the bus immediately.
  always_ff @(posedge PCLK_PM or negedge PRESETN_PM) begin
    if (!PRESETN_PM) begin
      state_q      <= S_IDLE;
      PSEL_PM      <= 1'b0;
      PENABLE_PM   <= 1'b0;
      PWRITE_PM    <= 1'b0;
      PADDR_PM     <= '0;
      PWDATA_PM    <= '0;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= '0;
      rsp_err      <= 1'b0;
      rsp_timeout  <= 1'b0;
      rsp_mismatch <= 1'b0;
      to_cnt_q     <= '0;
    end else begin
      state_q      <= state_d;
      PSEL_PM      <= psel_d;
      PENABLE_PM   <= penable_d;
      PWRITE_PM    <= pwrite_d;
      PADDR_PM     <= paddr_d;
      PWDATA_PM    <= pwdata_d;
      rsp_valid    <= rsp_valid_d;
      rsp_rdata    <= rsp_rdata_d;
      rsp_err      <= rsp_err_d;
      rsp_timeout  <= rsp_timeout_d;
      rsp_mismatch <= rsp_mismatch_d;
      to_cnt_q     <= to_cnt_d;
    end
  end

  // Next state and next register values; everything holds by default.
  always_comb begin
    state_d        = state_q;
    psel_d         = PSEL_PM;
    penable_d      = PENABLE_PM;
    pwrite_d       = PWRITE_PM;
    paddr_d        = PADDR_PM;
    pwdata_d       = PWDATA_PM;
    rsp_valid_d    = rsp_valid;
    rsp_rdata_d    = rsp_rdata;
    rsp_err_d      = rsp_err;
    rsp_timeout_d  = rsp_timeout;
    rsp_mismatch_d = rsp_mismatch;
    to_cnt_d       = to_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (pop) begin
          psel_d    = 1'b1;
          penable_d = 1'b0;
          pwrite_d  = h_write;
          paddr_d   = h_addr;
          pwdata_d  = h_write ? h_wdata : 32'd0;
          state_d   = S_SETUP;
        end
      end
      S_SETUP: begin
        penable_d = 1'b1;
        to_cnt_d  = '0;
        state_d   = S_ACCESS;
      end
      S_ACCESS: begin
        if (PREADY_PM) begin
          rsp_valid_d    = 1'b1;
          rsp_rdata_d    = PWRITE_PM ? 32'd0 : PRDATA_PM;
          rsp_err_d      = PSLVERR_PM;
          rsp_timeout_d  = 1'b0;
          rsp_mismatch_d = !PWRITE_PM && rd_miss;
          psel_d         = 1'b0;
          penable_d      = 1'b0;
          paddr_d        = '0;
          pwdata_d       = '0;
          state_d        = S_RESP;
        end else if (TO_EN && (to_cnt_q == TO_LAST)) begin
          rsp_valid_d    = 1'b1;
          rsp_rdata_d    = '0;
          rsp_err_d      = 1'b0;
          rsp_timeout_d  = 1'b1;
          rsp_mismatch_d = 1'b0;
          psel_d         = 1'b0;
          penable_d      = 1'b0;
          paddr_d        = '0;
          pwdata_d       = '0;
          state_d        = S_RESP;
        end else if (TO_EN) begin
          to_cnt_d = to_cnt_q + TW'(1);
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d    = 1'b0;
          rsp_rdata_d    = '0;
          rsp_err_d      = 1'b0;
          rsp_timeout_d  = 1'b0;
          rsp_mismatch_d = 1'b0;
          state_d        = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_bfm_apb_cmd_master.sv
// tb_bfm_apb_cmd_master: directed bench for bfm_apb_cmd_master
// (CMD_DEPTH=4, TIMEOUT=8). Table-driven single transfers, then hand-written
// sequences for back-pressure, timeout and reset during ACCESS.
module tb_bfm_apb_cmd_master;

`ifdef BFM_APBMASTER_RDCHK_EN
  localparam bit RDCHK = 1'b1;
`else
  localparam bit RDCHK = 1'b0;
`endif

  logic        PCLK_PM, PRESETN_PM;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata, cmd_exp, cmd_mask;
  logic        PSEL_PM, PWRITE_PM, PENABLE_PM, PREADY_PM, PSLVERR_PM;
  logic [31:0] PADDR_PM, PWDATA_PM, PRDATA_PM;
  logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout, rsp_mismatch, busy;
  logic [31:0] rsp_rdata;

  // Slave side: manual drive for directed cases, auto responder otherwise.
  logic        auto_slave, auto_rdy, man_rdy, man_err;
  logic [31:0] auto_data, man_data;
  assign PREADY_PM  = auto_slave ? auto_rdy : man_rdy;
  assign PRDATA_PM  = auto_slave ? auto_data : man_data;
  assign PSLVERR_PM = auto_slave ? 1'b0 : man_err;

  bfm_apb_cmd_master #(.CMD_DEPTH(4), .TIMEOUT(8), .TPD(1)) dut (
    .PCLK_PM(PCLK_PM), .PRESETN_PM(PRESETN_PM),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_exp(cmd_exp), .cmd_mask(cmd_mask),
    .PSEL_PM(PSEL_PM), .PADDR_PM(PADDR_PM), .PWRITE_PM(PWRITE_PM), .PENABLE_PM(PENABLE_PM),
    .PWDATA_PM(PWDATA_PM), .PRDATA_PM(PRDATA_PM), .PREADY_PM(PREADY_PM), .PSLVERR_PM(PSLVERR_PM),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .rsp_timeout(rsp_timeout), .rsp_mismatch(rsp_mismatch), .busy(busy)
  );

  // ---------------- clock / reset ----------------
  initial begin
    PCLK_PM = 1'b0;
    forever #5 PCLK_PM = ~PCLK_PM;
  end

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  task automatic tick();
    @(posedge PCLK_PM);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, expv);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b", name, act, expv);
    end
  endtask

  // Auto responder: one-cycle PREADY on the first ACCESS cycle.
  initial begin
    auto_rdy  = 1'b0;
    auto_data = '0;
    forever begin
      tick();
      if (auto_slave && PSEL_PM && PENABLE_PM && !auto_rdy) begin
        auto_rdy  = 1'b1;
        auto_data = {16'hC0DE, PADDR_PM[15:0]};
      end else begin
        auto_rdy  = 1'b0;
      end
    end
  end

  // PENABLE low-gap monitor between successive transfers.
  logic gap_mon;
  int   low_cnt, min_gap, n_gaps;
  logic seen_high;
  initial begin
    low_cnt = 0; min_gap = 1000; n_gaps = 0; seen_high = 1'b0;
    forever begin
      tick();
      if (!gap_mon) begin
        low_cnt = 0; min_gap = 1000; n_gaps = 0; seen_high = 1'b0;
      end else if (PENABLE_PM) begin
        if (seen_high && low_cnt > 0) begin
          n_gaps++;
          if (low_cnt < min_gap) min_gap = low_cnt;
        end
        seen_high = 1'b1;
        low_cnt   = 0;
      end else begin
        low_cnt++;
      end
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic        write;
    logic [31:0] addr, wdata, exp, mask;
    int          wait_cyc;
    logic [31:0] prdata;
    logic        slverr;
    logic [31:0] x_rdata;
    logic        x_err, x_mis;
  } vec_t;
  vec_t vecs[5];

  // One complete transfer with the manual slave, checked cycle by cycle.
  task automatic run_txn(input vec_t v);
    int n;
    cmd_write = v.write; cmd_addr = v.addr; cmd_wdata = v.wdata;
    cmd_exp = v.exp; cmd_mask = v.mask;
    chk1("cmd_ready_idle", cmd_ready, 1'b1);
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    chk1("psel_early", PSEL_PM, 1'b0);
    n = 0;
    while (!PSEL_PM && n < 16) begin tick(); n++; end
    check("setup_latency", n, 32'd1);
    chk1("setup_penable", PENABLE_PM, 1'b0);
    check("setup_paddr", PADDR_PM, v.addr);
    chk1("setup_pwrite", PWRITE_PM, v.write);
    check("setup_pwdata", PWDATA_PM, v.write ? v.wdata : 32'd0);
    man_err  = ~v.slverr;
    man_data = 32'h5A5A_0F0F;
    tick();
    chk1("access_penable", PENABLE_PM, 1'b1);
    for (int k = 0; k < v.wait_cyc; k++) begin
      tick();
      chk1("hold_penable", PENABLE_PM, 1'b1);
      check("hold_paddr", PADDR_PM, v.addr);
      check("hold_pwdata", PWDATA_PM, v.write ? v.wdata : 32'd0);
    end
    man_rdy = 1'b1; man_data = v.prdata; man_err = v.slverr;
    tick();
    man_rdy = 1'b0; man_data = 32'h5A5A_0F0F; man_err = 1'b0;
    chk1("rsp_valid", rsp_valid, 1'b1);
    check("rsp_rdata", rsp_rdata, v.x_rdata);
    chk1("rsp_err", rsp_err, v.x_err);
    chk1("rsp_timeout", rsp_timeout, 1'b0);
    chk1("rsp_mismatch", rsp_mismatch, v.x_mis);
    chk1("end_psel", PSEL_PM, 1'b0);
    chk1("end_penable", PENABLE_PM, 1'b0);
    check("end_paddr", PADDR_PM, 32'd0);
    tick();
    chk1("rsp_hold", rsp_valid, 1'b1);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk1("rsp_cleared", rsp_valid, 1'b0);
    chk1("rsp_err_cleared", rsp_err, 1'b0);
    chk1("idle_busy", busy, 1'b0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    logic [31:0] a;
    logic seen;
    PRESETN_PM = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    cmd_exp = '0; cmd_mask = '0; rsp_ready = 1'b0;
    auto_slave = 1'b0; man_rdy = 1'b0; man_err = 1'b0; man_data = '0; gap_mon = 1'b0;

    vecs[0] = '{1'b1, 32'h0100_0004, 32'hDEAD_BEEF, 32'h0, 32'h0, 3, 32'h1111_2222, 1'b0, 32'h0, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 32'h0200_0010, 32'hFFFF_FFFF, 32'h0, 32'h0, 0, 32'h1234_5678, 1'b1, 32'h1234_5678, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 32'h0300_0020, 32'h0, 32'hA5A5_0000, 32'hFFFF_0000, 1, 32'hA5A5_1234, 1'b0, 32'hA5A5_1234, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 32'h0300_0024, 32'h0, 32'hA5A5_0000, 32'hFFFF_0000, 2, 32'hA4A5_1234, 1'b0, 32'hA4A5_1234, 1'b0, RDCHK};
    vecs[4] = '{1'b1, 32'h0400_0008, 32'h0BAD_F00D, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'h0, 1'b1, 32'h0, 1'b1, 1'b0};

    repeat (3) tick();
    chk1("rst_psel", PSEL_PM, 1'b0);
    chk1("rst_penable", PENABLE_PM, 1'b0);
    chk1("rst_pwrite", PWRITE_PM, 1'b0);
    check("rst_paddr", PADDR_PM, 32'd0);
    check("rst_pwdata", PWDATA_PM, 32'd0);
    chk1("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk1("rst_rsp_err", rsp_err, 1'b0);
    chk1("rst_rsp_timeout", rsp_timeout, 1'b0);
    chk1("rst_rsp_mismatch", rsp_mismatch, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_cmd_ready", cmd_ready, 1'b1);
    PRESETN_PM = 1'b1;
    tick();

    for (int i = 0; i < 5; i++) run_txn(vecs[i]);

    // Back-pressure: five commands, responses held off, then drained in order.
    auto_slave = 1'b1; gap_mon = 1'b1; rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      a = 32'h1000_0000 + 32'(i * 4);
      cmd_write = i[0]; cmd_addr = a; cmd_wdata = 32'h7000_0000 + 32'(i);
      exp_q.push_back(i[0] ? 32'd0 : {16'hC0DE, a[15:0]});
      cmd_valid = 1'b1;
      n = 0;
      while (!cmd_ready && n < 32) begin tick(); n++; end
      chk1("bp_push_ready", cmd_ready, 1'b1);
      tick();
    end
    cmd_valid = 1'b0;
    tick();
    chk1("bp_full", cmd_ready, 1'b0);
    chk1("bp_rsp_held", rsp_valid, 1'b1);
    chk1("bp_busy", busy, 1'b1);
    rsp_ready = 1'b1;
    n = 0;
    while (exp_q.size() > 0 && n < 200) begin
      if (rsp_valid) check("bp_order_rdata", rsp_rdata, exp_q.pop_front());
      tick();
      n++;
    end
    check("bp_all_done", exp_q.size(), 32'd0);
    rsp_ready = 1'b0;
    repeat (3) tick();
    chk1("bp_idle_busy", busy, 1'b0);
    check("bp_gap_count", n_gaps, 32'd4);
    chk1("bp_min_gap_ge2", min_gap >= 2, 1'b1);
    gap_mon = 1'b0; auto_slave = 1'b0;

    // Timeout: slave never answers; abort after 8 ACCESS cycles.
    man_rdy = 1'b0; man_err = 1'b1; man_data = 32'hBAD0_BAD0;
    cmd_write = 1'b0; cmd_addr = 32'h0500_0000; cmd_wdata = 32'h0;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    n = 0;
    while (!PENABLE_PM && n < 16) begin tick(); n++; end
    chk1("to_access_seen", PENABLE_PM, 1'b1);
    n = 0;
    while (PENABLE_PM && n < 64) begin tick(); n++; end
    check("to_access_cycles", n, 32'd8);
    chk1("to_rsp_valid", rsp_valid, 1'b1);
    chk1("to_rsp_timeout", rsp_timeout, 1'b1);
    chk1("to_rsp_err", rsp_err, 1'b0);
    check("to_rsp_rdata", rsp_rdata, 32'd0);
    chk1("to_psel", PSEL_PM, 1'b0);
    cmd_write = 1'b1; cmd_addr = 32'h0500_0004; cmd_wdata = 32'h0000_CAFE;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    chk1("to_resp_hold", rsp_valid, 1'b1);
    chk1("to_queued_no_psel", PSEL_PM, 1'b0);
    man_err = 1'b0; auto_slave = 1'b1; rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk1("to_flag_cleared", rsp_timeout, 1'b0);
    n = 0;
    while (!rsp_valid && n < 32) begin tick(); n++; end
    chk1("to_next_valid", rsp_valid, 1'b1);
    chk1("to_next_timeout", rsp_timeout, 1'b0);
    check("to_next_rdata", rsp_rdata, 32'd0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0; auto_slave = 1'b0;
    chk1("to_idle_busy", busy, 1'b0);

    // Reset during ACCESS with two commands still queued.
    for (int i = 0; i < 3; i++) begin
      cmd_write = (i == 0); cmd_addr = 32'h0600_0000 + 32'(i * 4); cmd_wdata = 32'hFACE_0000 + 32'(i);
      cmd_valid = 1'b1;
      tick();
    end
    cmd_valid = 1'b0;
    n = 0;
    while (!PENABLE_PM && n < 16) begin tick(); n++; end
    chk1("rm_in_access", PENABLE_PM, 1'b1);
    chk1("rm_pwrite_before", PWRITE_PM, 1'b1);
    #2;
    PRESETN_PM = 1'b0;
    #1;
    chk1("rm_psel", PSEL_PM, 1'b0);
    chk1("rm_penable", PENABLE_PM, 1'b0);
    chk1("rm_pwrite", PWRITE_PM, 1'b0);
    check("rm_paddr", PADDR_PM, 32'd0);
    check("rm_pwdata", PWDATA_PM, 32'd0);
    chk1("rm_busy", busy, 1'b0);
    chk1("rm_cmd_ready", cmd_ready, 1'b1);
    tick(); tick();
    PRESETN_PM = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (rsp_valid || PSEL_PM) seen = 1'b1;
    end
    chk1("rm_no_activity", seen, 1'b0);
    chk1("rm_busy_after", busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
